// File: rtl/sda_kernel_control_regs.sv
// AXI4-Lite control/status register block for an SDAccel-style kernel.
// Holds ap_start/ap_done/ap_idle, the interrupt enable/status registers and
// the scalar argument registers, and talks go/done to the kernel reset handler.
//
// Handshake rule on every channel (AW, W, B, AR, R): a transfer happens on a
// rising clock edge where both valid and ready are high. A source holds valid
// and its payload unchanged until that edge. Ready may be asserted before valid.
module sda_kernel_control_regs #(
  parameter int AddrWidth = 6,
  parameter int ArgCount  = 4
) (
  input  logic                    clk,
  input  logic                    sysRstN,
  input  logic                    sAxiAwValid,
  output logic                    sAxiAwReady,
  input  logic [AddrWidth-1:0]    sAxiAwAddr,
  input  logic                    sAxiWValid,
  output logic                    sAxiWReady,
  input  logic [31:0]             sAxiWData,
  input  logic [3:0]              sAxiWStrb,
  output logic                    sAxiBValid,
  input  logic                    sAxiBReady,
  output logic [1:0]              sAxiBResp,
  input  logic                    sAxiArValid,
  output logic                    sAxiArReady,
  input  logic [AddrWidth-1:0]    sAxiArAddr,
  output logic                    sAxiRValid,
  input  logic                    sAxiRReady,
  output logic [31:0]             sAxiRData,
  output logic [1:0]              sAxiRResp,
  output logic                    regGoValid,
  input  logic                    regGoHoldoff,
  input  logic                    regDoneValid,
  output logic                    regDoneStop,
  output logic [32*ArgCount-1:0]  kernelArgs,
  output logic                    interrupt
);

  // Word index into the register map (byte address bits [1:0] ignored).
  localparam int IdxW = AddrWidth - 2;

  logic              alive;
  logic              aw_full;
  logic              w_full;
  logic [IdxW-1:0]   aw_idx;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic              b_valid;
  logic              r_valid;
  logic [31:0]       r_data;
  logic              start;
  logic              done;
  logic              idle;
  logic              gie;
  logic              ier;
  logic              isr;
  logic              irq;
  logic [31:0]       args [ArgCount];

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              wr_commit;
  logic              go_fire;
  logic [IdxW-1:0]   ar_idx;
  logic [31:0]       rd_word;
  logic              wr_ctrl;
  logic              wr_gie;
  logic              wr_ier;
  logic              wr_isr;
  logic [ArgCount-1:0] wr_arg_sel;

  // Ready lines stay low until the first clock after reset release.
  assign sAxiAwReady = alive & ~aw_full & ~b_valid;
  assign sAxiWReady  = alive & ~w_full & ~b_valid;
  assign sAxiArReady = alive & ~r_valid;
  assign sAxiBValid  = b_valid;
  assign sAxiBResp   = 2'b00;
  assign sAxiRValid  = r_valid;
  assign sAxiRData   = r_data;
  assign sAxiRResp   = 2'b00;

  assign aw_hs     = sAxiAwValid & sAxiAwReady;
  assign w_hs      = sAxiWValid & sAxiWReady;
  assign ar_hs     = sAxiArValid & sAxiArReady;
  assign wr_commit = aw_full & w_full;
  assign go_fire   = start & ~regGoHoldoff;
  assign ar_idx    = sAxiArAddr[AddrWidth-1:2];

  assign regGoValid  = start;
  assign regDoneStop = ~alive;
  assign interrupt   = irq;

  // Read mux: unmapped words return zero.
  always_comb begin
    rd_word = 32'd0;
    case (ar_idx)
      IdxW'(0): rd_word = {29'd0, idle, done, start};
      IdxW'(1): rd_word = {31'd0, gie};
      IdxW'(2): rd_word = {31'd0, ier};
      IdxW'(3): rd_word = {31'd0, isr};
      default: begin
        for (int n = 0; n < ArgCount; n++) begin
          if (ar_idx == IdxW'(4 + n)) rd_word = args[n];
        end
      end
    endcase
  end

  // Write decode, qualified by the commit cycle; unmapped writes do nothing.
  always_comb begin
    wr_ctrl    = wr_commit & (aw_idx == IdxW'(0));
    wr_gie     = wr_commit & (aw_idx == IdxW'(1));
    wr_ier     = wr_commit & (aw_idx == IdxW'(2));
    wr_isr     = wr_commit & (aw_idx == IdxW'(3));
    wr_arg_sel = '0;
    for (int n = 0; n < ArgCount; n++) begin
      wr_arg_sel[n] = wr_commit & (aw_idx == IdxW'(4 + n));
    end
  end

  // Write channel: independent AW/W slots, commit when both full, then B.
  always_ff @(posedge clk or negedge sysRstN) begin
    if (!sysRstN) begin
      alive   <= 1'b0;
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= 32'd0;
      w_strb  <= 4'd0;
      b_valid <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= sAxiAwAddr[AddrWidth-1:2];
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= sAxiWData;
        w_strb <= sAxiWStrb;
      end
      if (wr_commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        b_valid <= 1'b1;
      end else if (b_valid && sAxiBReady) begin
        b_valid <= 1'b0;
      end
    end
  end

  // Read channel: data captured at AR accept and held until R handshake.
  always_ff @(posedge clk or negedge sysRstN) begin
    if (!sysRstN) begin
      r_valid <= 1'b0;
      r_data  <= 32'd0;
    end else if (ar_hs) begin
      r_valid <= 1'b1;
      r_data  <= rd_word;
    end else if (r_valid && sAxiRReady) begin
      r_valid <= 1'b0;
    end
  end

  // Control/status: later assignments win, so a done event overrides the
  // clear-on-read of done and the ISR toggle in the same cycle.
  always_ff @(posedge clk or negedge sysRstN) begin
    if (!sysRstN) begin
      start <= 1'b0;
      done  <= 1'b0;
      idle  <= 1'b1;
      gie   <= 1'b0;
      ier   <= 1'b0;
      isr   <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (go_fire) begin
        start <= 1'b0;
        idle  <= 1'b0;
      end
      if (wr_ctrl && w_strb[0] && w_data[0] && idle && !go_fire) start <= 1'b1;
      if (wr_gie && w_strb[0]) gie <= w_data[0];
      if (wr_ier && w_strb[0]) ier <= w_data[0];
      if (wr_isr && w_strb[0] && w_data[0]) isr <= ~isr;
      if (ar_hs && (ar_idx == IdxW'(0))) done <= 1'b0;
      if (regDoneValid) begin
        done <= 1'b1;
        idle <= 1'b1;
        if (ier) isr <= 1'b1;
      end
      irq <= gie & ier & isr;
    end
  end

  // Argument registers with per-byte strobes.
  always_ff @(posedge clk or negedge sysRstN) begin
    if (!sysRstN) begin
      for (int n = 0; n < ArgCount; n++) args[n] <= 32'd0;
    end else begin
      for (int n = 0; n < ArgCount; n++) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_arg_sel[n] && w_strb[b]) args[n][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

  // Flatten argument registers onto the output bus.
  always_comb begin
    kernelArgs = '0;
    for (int n = 0; n < ArgCount; n++) kernelArgs[32*n +: 32] = args[n];
  end

endmodule

// File: tb/tb_sda_kernel_control_regs.sv
// Directed bench for sda_kernel_control_regs.
module tb_sda_kernel_control_regs;

  localparam int AddrWidth = 6;
  localparam int ArgCount  = 4;
  localparam int Budget    = 20;

  logic                   clk;
  logic                   sysRstN;
  logic                   sAxiAwValid;
  logic                   sAxiAwReady;
  logic [AddrWidth-1:0]   sAxiAwAddr;
  logic                   sAxiWValid;
  logic                   sAxiWReady;
  logic [31:0]            sAxiWData;
  logic [3:0]             sAxiWStrb;
  logic                   sAxiBValid;
  logic                   sAxiBReady;
  logic [1:0]             sAxiBResp;
  logic                   sAxiArValid;
  logic                   sAxiArReady;
  logic [AddrWidth-1:0]   sAxiArAddr;
  logic                   sAxiRValid;
  logic                   sAxiRReady;
  logic [31:0]            sAxiRData;
  logic [1:0]             sAxiRResp;
  logic                   regGoValid;
  logic                   regGoHoldoff;
  logic                   regDoneValid;
  logic                   regDoneStop;
  logic [32*ArgCount-1:0] kernelArgs;
  logic                   interrupt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd;

  sda_kernel_control_regs #(.AddrWidth(AddrWidth), .ArgCount(ArgCount)) dut (
    .clk(clk), .sysRstN(sysRstN),
    .sAxiAwValid(sAxiAwValid), .sAxiAwReady(sAxiAwReady), .sAxiAwAddr(sAxiAwAddr),
    .sAxiWValid(sAxiWValid), .sAxiWReady(sAxiWReady), .sAxiWData(sAxiWData),
    .sAxiWStrb(sAxiWStrb),
    .sAxiBValid(sAxiBValid), .sAxiBReady(sAxiBReady), .sAxiBResp(sAxiBResp),
    .sAxiArValid(sAxiArValid), .sAxiArReady(sAxiArReady), .sAxiArAddr(sAxiArAddr),
    .sAxiRValid(sAxiRValid), .sAxiRReady(sAxiRReady), .sAxiRData(sAxiRData),
    .sAxiRResp(sAxiRResp),
    .regGoValid(regGoValid), .regGoHoldoff(regGoHoldoff),
    .regDoneValid(regDoneValid), .regDoneStop(regDoneStop),
    .kernelArgs(kernelArgs), .interrupt(interrupt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic axi_write(input logic [AddrWidth-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input string tag);
    logic aw_done, w_done, aw_hs, w_hs, b_hs, b_done;
    int cnt;
    sAxiAwValid = 1'b1; sAxiAwAddr = addr;
    sAxiWValid  = 1'b1; sAxiWData = data; sAxiWStrb = strb;
    aw_done = 1'b0; w_done = 1'b0; cnt = 0;
    while (!(aw_done && w_done) && cnt < Budget) begin
      aw_hs = sAxiAwValid && sAxiAwReady;
      w_hs  = sAxiWValid && sAxiWReady;
      step(1);
      if (aw_hs) begin sAxiAwValid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin sAxiWValid  = 1'b0; w_done  = 1'b1; end
      cnt++;
    end
    sAxiAwValid = 1'b0; sAxiWValid = 1'b0;
    check({tag, "_addr_data_accept"}, {30'd0, aw_done, w_done}, 32'd3);
    sAxiBReady = 1'b1;
    b_done = 1'b0; cnt = 0;
    while (!b_done && cnt < Budget) begin
      b_hs = sAxiBValid && sAxiBReady;
      if (b_hs) check({tag, "_bresp"}, {30'd0, sAxiBResp}, 32'd0);
      step(1);
      if (b_hs) b_done = 1'b1;
      cnt++;
    end
    sAxiBReady = 1'b0;
    check({tag, "_bvalid_seen"}, {31'd0, b_done}, 32'd1);
  endtask

  task automatic axi_read(input logic [AddrWidth-1:0] addr, output logic [31:0] data,
                          input string tag);
    logic ar_done, r_done, hs;
    int cnt;
    data = 32'hxxxx_xxxx;
    sAxiArValid = 1'b1; sAxiArAddr = addr;
    ar_done = 1'b0; cnt = 0;
    while (!ar_done && cnt < Budget) begin
      hs = sAxiArValid && sAxiArReady;
      step(1);
      if (hs) begin sAxiArValid = 1'b0; ar_done = 1'b1; end
      cnt++;
    end
    sAxiArValid = 1'b0;
    sAxiRReady = 1'b1;
    r_done = 1'b0; cnt = 0;
    while (!r_done && cnt < Budget) begin
      hs = sAxiRValid && sAxiRReady;
      if (hs) data = sAxiRData;
      step(1);
      if (hs) r_done = 1'b1;
      cnt++;
    end
    sAxiRReady = 1'b0;
    check({tag, "_read_done"}, {30'd0, ar_done, r_done}, 32'd3);
  endtask

  initial begin
    sysRstN = 1'b0;
    sAxiAwValid = 1'b0; sAxiAwAddr = '0;
    sAxiWValid = 1'b0; sAxiWData = 32'd0; sAxiWStrb = 4'd0;
    sAxiBReady = 1'b0;
    sAxiArValid = 1'b0; sAxiArAddr = '0;
    sAxiRReady = 1'b0;
    regGoHoldoff = 1'b0;
    regDoneValid = 1'b0;

    // Reset state
    step(3);
    check("rst_readies", {29'd0, sAxiAwReady, sAxiWReady, sAxiArReady}, 32'd0);
    check("rst_valids", {30'd0, sAxiBValid, sAxiRValid}, 32'd0);
    check("rst_go_valid", {31'd0, regGoValid}, 32'd0);
    check("rst_done_stop", {31'd0, regDoneStop}, 32'd1);
    check("rst_interrupt", {31'd0, interrupt}, 32'd0);
    check("rst_args", kernelArgs[31:0] | kernelArgs[63:32] | kernelArgs[95:64] | kernelArgs[127:96], 32'd0);
    sysRstN = 1'b1;
    step(2);
    check("run_done_stop", {31'd0, regDoneStop}, 32'd0);
    axi_read(6'h00, rd, "ctrl0");
    check("ctrl_after_reset", rd, 32'h4);
    axi_write(6'h10, 32'hDEAD_BEEF, 4'hF, "arg0");
    axi_read(6'h10, rd, "arg0_rd");
    check("arg0_readback", rd, 32'hDEAD_BEEF);
    check("arg0_port", kernelArgs[31:0], 32'hDEAD_BEEF);
    axi_read(6'h3C, rd, "unmapped");
    check("unmapped_read", rd, 32'h0);

    // Go with holdoff
    regGoHoldoff = 1'b1;
    axi_write(6'h00, 32'h1, 4'hF, "go");
    for (int i = 0; i < 5; i++) begin
      check("go_held", {31'd0, regGoValid}, 32'd1);
      step(1);
    end
    regGoHoldoff = 1'b0;
    step(1);
    check("go_accepted", {31'd0, regGoValid}, 32'd0);
    axi_read(6'h00, rd, "ctrl_busy");
    check("ctrl_busy", rd, 32'h0);

    // Start ignored while busy; byte-strobe arg write
    axi_write(6'h00, 32'h1, 4'hF, "go_busy");
    step(1);
    check("go_busy_ignored", {31'd0, regGoValid}, 32'd0);
    axi_write(6'h14, 32'hAABB_CCDD, 4'b0010, "arg1");
    check("arg1_strobe", kernelArgs[63:32], 32'h0000_CC00);

    // Done, interrupt, clear-on-read, ISR toggle
    axi_write(6'h04, 32'h1, 4'hF, "gie");
    axi_write(6'h08, 32'h1, 4'hF, "ier");
    regDoneValid = 1'b1;
    step(1);
    regDoneValid = 1'b0;
    check("irq_not_yet", {31'd0, interrupt}, 32'd0);
    step(1);
    check("irq_set", {31'd0, interrupt}, 32'd1);
    axi_read(6'h00, rd, "ctrl_done");
    check("ctrl_done", rd, 32'h6);
    axi_read(6'h00, rd, "ctrl_cleared");
    check("ctrl_cleared", rd, 32'h4);
    axi_write(6'h0C, 32'h1, 4'hF, "isr_toggle");
    check("irq_cleared", {31'd0, interrupt}, 32'd0);
    axi_read(6'h0C, rd, "isr");
    check("isr_zero", rd, 32'h0);

    // W leads AW by 3 cycles, BReady held low
    sAxiWValid = 1'b1; sAxiWData = 32'h1234_5678; sAxiWStrb = 4'hF;
    check("w_lead_ready", {31'd0, sAxiWReady}, 32'd1);
    step(1);
    sAxiWValid = 1'b0;
    step(2);
    check("w_lead_no_b", {31'd0, sAxiBValid}, 32'd0);
    check("w_lead_aw_ready", {31'd0, sAxiAwReady}, 32'd1);
    check("w_lead_w_full", {31'd0, sAxiWReady}, 32'd0);
    sAxiAwValid = 1'b1; sAxiAwAddr = 6'h18;
    step(1);
    sAxiAwValid = 1'b0;
    step(1);
    for (int i = 0; i < 4; i++) begin
      check("b_held", {29'd0, sAxiBValid, sAxiAwReady, sAxiWReady}, 32'h4);
      step(1);
    end
    check("arg2_value", kernelArgs[95:64], 32'h1234_5678);
    sAxiBReady = 1'b1;
    step(1);
    sAxiBReady = 1'b0;
    check("b_released", {31'd0, sAxiBValid}, 32'd0);
    step(3);
    check("no_second_b", {31'd0, sAxiBValid}, 32'd0);

    // Reset during a pending read
    regGoHoldoff = 1'b1;
    axi_write(6'h00, 32'h1, 4'hF, "go2");
    check("go2_valid", {31'd0, regGoValid}, 32'd1);
    sAxiArValid = 1'b1; sAxiArAddr = 6'h00;
    step(1);
    sAxiArValid = 1'b0;
    check("pend_rvalid", {31'd0, sAxiRValid}, 32'd1);
    check("pend_rdata", sAxiRData, 32'h5);
    sysRstN = 1'b0;
    #1;
    check("rst_rvalid", {31'd0, sAxiRValid}, 32'd0);
    check("rst_done_stop2", {31'd0, regDoneStop}, 32'd1);
    check("rst_go2", {31'd0, regGoValid}, 32'd0);
    check("rst_args2", kernelArgs[95:64], 32'd0);
    step(2);
    regGoHoldoff = 1'b0;
    sysRstN = 1'b1;
    step(2);
    check("rst2_no_r", {31'd0, sAxiRValid}, 32'd0);
    axi_read(6'h00, rd, "ctrl_post_rst");
    check("ctrl_post_rst", rd, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
